// File: rtl/tdc_diff_pkg.sv
// Shared defaults and the pairing state type for the timestamp pair-difference averager.
package tdc_diff_pkg;

    localparam int          IN_W_DEF   = 37;
    localparam int          OUT_W_DEF  = 20;
    localparam logic [19:0] OFFSET_DEF = 20'h007F0;
    localparam int          HOLD_DEF   = 16;

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } pair_state_e;

endpackage

// File: rtl/diff_sat.sv
// Narrows a signed wide value to OUT_W bits, either by signed clipping or by plain truncation.
module diff_sat #(
    parameter int IN_WIDE = 39,
    parameter int OUT_W   = 20,
    parameter bit SAT_EN  = 1'b1
) (
    input  logic signed [IN_WIDE-1:0] i_val,
    output logic        [OUT_W-1:0]   o_val,
    output logic                      o_sat
);

    logic [IN_WIDE-OUT_W:0] w_upper;
    logic                   w_fits;

    // The value fits when every bit from the output sign bit upward matches.
    assign w_upper = i_val[IN_WIDE-1:OUT_W-1];
    assign w_fits  = (&w_upper) || !(|w_upper);

    // NOTE: every output gets a default first, so no path through the block can infer a latch.
    always_comb begin
        o_val = i_val[OUT_W-1:0];
        o_sat = 1'b0;
        if (SAT_EN && !w_fits) begin
            o_sat = 1'b1;
            o_val = i_val[IN_WIDE-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                     : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/pair_diff_avg.sv
// Pairs A/B timestamps, forms offset differences, averages 2^AVG_LOG2 of them
// and presents each clipped result with a stability flag after HOLD quiet cycles.
module pair_diff_avg
    import tdc_diff_pkg::*;
#(
    parameter int               IN_W     = IN_W_DEF,
    parameter int               OUT_W    = OUT_W_DEF,
    parameter logic [OUT_W-1:0] OFFSET   = OUT_W'(OFFSET_DEF),
    parameter int               AVG_LOG2 = 0,
    parameter bit               SAT_EN   = 1'b1,
    parameter int               HOLD     = HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dval,
    input  logic [IN_W-1:0]  mlt,
    input  logic             pair_sync,
    input  logic             mode_neg,
    output logic [OUT_W-1:0] out_data,
    output logic             res_vld,
    output logic             o_dval,
    output logic             sat_flag
);

    localparam int DW = IN_W + 2;
    localparam int AW = DW + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int QW = $clog2(HOLD + 1);
    localparam logic [CW-1:0]        CNT_LAST   = CW'((1 << AVG_LOG2) - 1);
    localparam logic signed [DW-1:0] OFFSET_EXT = DW'(signed'(OFFSET));

    pair_state_e r_state, w_next;
    logic        w_cap_a, w_cap_b;

    logic [IN_W-1:0]        r_a, r_b;
    logic                   r_neg, r_b_vld;
    logic signed [DW-1:0]   r_d;
    logic                   r_d_vld;
    logic signed [AW-1:0]   r_acc;
    logic [CW-1:0]          r_cnt;
    logic [QW-1:0]          r_quiet;

    logic signed [DW-1:0]   w_a_ext, w_b_ext, w_d_next;
    logic signed [AW-1:0]   w_d_ext, w_sum, w_shift;
    logic                   w_last, w_emit;
    logic [OUT_W-1:0]       w_sat_val;
    logic                   w_sat_flag;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= WAIT_A;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (dval) begin
            case (r_state)
                WAIT_A:  w_next = WAIT_B;
                WAIT_B:  if (!pair_sync) w_next = WAIT_A;
                default: w_next = WAIT_A;
            endcase
        end
    end

    always_comb begin
        w_cap_a = 1'b0;
        w_cap_b = 1'b0;
        if (dval) begin
            case (r_state)
                WAIT_A:  w_cap_a = 1'b1;
                WAIT_B:  if (pair_sync) w_cap_a = 1'b1; else w_cap_b = 1'b1;
                default: w_cap_a = 1'b0;
            endcase
        end
    end

    // Capture stage: A stays valid through stage 1 because a new A can land only after B.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_neg   <= 1'b0;
            r_b_vld <= 1'b0;
        end else begin
            r_b_vld <= w_cap_b;
            if (w_cap_a) r_a <= mlt;
            if (w_cap_b) begin
                r_b   <= mlt;
                r_neg <= mode_neg;
            end
        end
    end

    assign w_a_ext  = $signed({2'b00, r_a});
    assign w_b_ext  = $signed({2'b00, r_b});
    assign w_d_next = (r_neg ? (w_a_ext - w_b_ext) : (w_b_ext - w_a_ext)) + OFFSET_EXT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d     <= '0;
            r_d_vld <= 1'b0;
        end else begin
            r_d     <= w_d_next;
            r_d_vld <= r_b_vld;
        end
    end

    assign w_d_ext = AW'(r_d);
    assign w_sum   = r_acc + w_d_ext;
    assign w_shift = w_sum >>> AVG_LOG2;
    assign w_last  = (r_cnt == CNT_LAST);
    assign w_emit  = r_d_vld && w_last;

    diff_sat #(
        .IN_WIDE (AW),
        .OUT_W   (OUT_W),
        .SAT_EN  (SAT_EN)
    ) u_diff_sat (
        .i_val (w_shift),
        .o_val (w_sat_val),
        .o_sat (w_sat_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            out_data <= '0;
            sat_flag <= 1'b0;
            res_vld  <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            if (w_emit) begin
                r_acc    <= '0;
                r_cnt    <= '0;
                out_data <= w_sat_val;
                sat_flag <= w_sat_flag;
                res_vld  <= 1'b1;
            end else if (r_d_vld) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Quiet counter saturates at HOLD; o_dval rises on the edge it gets there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quiet <= QW'(HOLD);
            o_dval  <= 1'b1;
        end else if (w_emit) begin
            r_quiet <= '0;
            o_dval  <= 1'b0;
        end else if (r_quiet != QW'(HOLD)) begin
            r_quiet <= r_quiet + QW'(1);
            o_dval  <= (r_quiet == QW'(HOLD - 1));
        end
    end

endmodule

// File: tb/tb_pair_diff_avg.sv
// Drives three configurations of pair_diff_avg from shared inputs and checks them against a queue-based model.
module tb_pair_diff_avg;

    localparam int    NI   = 3;
    localparam longint OFFS = 2032;
    localparam longint HOLD = 16;
    localparam longint SMAX = 524287;
    localparam longint SMIN = -524288;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dval = 1'b0;
    logic [36:0] mlt = '0;
    logic        pair_sync = 1'b0;
    logic        mode_neg = 1'b0;

    logic [19:0] dut_out [NI];
    logic        dut_vld [NI];
    logic        dut_dv  [NI];
    logic        dut_sat [NI];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pair_diff_avg u_def (
        .clk(clk), .rst(rst), .dval(dval), .mlt(mlt), .pair_sync(pair_sync), .mode_neg(mode_neg),
        .out_data(dut_out[0]), .res_vld(dut_vld[0]), .o_dval(dut_dv[0]), .sat_flag(dut_sat[0])
    );

    pair_diff_avg #(.SAT_EN(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .dval(dval), .mlt(mlt), .pair_sync(pair_sync), .mode_neg(mode_neg),
        .out_data(dut_out[1]), .res_vld(dut_vld[1]), .o_dval(dut_dv[1]), .sat_flag(dut_sat[1])
    );

    pair_diff_avg #(.AVG_LOG2(2)) u_avg (
        .clk(clk), .rst(rst), .dval(dval), .mlt(mlt), .pair_sync(pair_sync), .mode_neg(mode_neg),
        .out_data(dut_out[2]), .res_vld(dut_vld[2]), .o_dval(dut_dv[2]), .sat_flag(dut_sat[2])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pairing rules, a delay queue for the two-edge latency, group averaging.
    typedef struct { longint t; longint d; } pend_t;
    pend_t  q[$];
    int     m_lg[NI]    = '{0, 0, 2};
    bit     m_sat_en[NI] = '{1'b1, 1'b0, 1'b1};
    longint m_sum[NI], m_out[NI], m_quiet[NI];
    int     m_cnt[NI];
    bit     m_vld[NI], m_satf[NI];
    bit     m_ready = 1'b0;
    bit     m_have_a = 1'b0;
    longint m_a = 0;
    longint cyc = 0;

    always @(posedge clk) begin
        bit     got;
        longint dd, avg, v;
        cyc++;
        got = 1'b0;
        dd  = 0;
        if (rst) begin
            q.delete();
            m_have_a = 1'b0;
            m_ready  = 1'b1;
            for (int k = 0; k < NI; k++) begin
                m_sum[k] = 0; m_cnt[k] = 0; m_out[k] = 0;
                m_vld[k] = 1'b0; m_satf[k] = 1'b0; m_quiet[k] = HOLD;
            end
        end else begin
            if (q.size() > 0 && q[0].t == cyc) begin
                dd  = q[0].d;
                got = 1'b1;
                void'(q.pop_front());
            end
            for (int k = 0; k < NI; k++) begin
                m_vld[k] = 1'b0;
                if (got) begin
                    m_sum[k] += dd;
                    m_cnt[k]++;
                    if (m_cnt[k] == (1 << m_lg[k])) begin
                        avg = m_sum[k] >>> m_lg[k];
                        if (m_sat_en[k] && avg > SMAX) begin
                            v = SMAX; m_satf[k] = 1'b1;
                        end else if (m_sat_en[k] && avg < SMIN) begin
                            v = SMIN; m_satf[k] = 1'b1;
                        end else begin
                            v = avg; m_satf[k] = 1'b0;
                        end
                        m_out[k]   = v;
                        m_vld[k]   = 1'b1;
                        m_sum[k]   = 0;
                        m_cnt[k]   = 0;
                    end
                end
                if (m_vld[k])              m_quiet[k] = 0;
                else if (m_quiet[k] < HOLD) m_quiet[k]++;
            end
            if (dval) begin
                if (!m_have_a) begin
                    m_a = longint'(mlt); m_have_a = 1'b1;
                end else if (pair_sync) begin
                    m_a = longint'(mlt);
                end else begin
                    q.push_back('{t: cyc + 2,
                                  d: (mode_neg ? (m_a - longint'(mlt)) : (longint'(mlt) - m_a)) + OFFS});
                    m_have_a = 1'b0;
                end
            end
        end
        #1;
        if (m_ready) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("model_out[%0d]", k), 64'(dut_out[k]), m_out[k] & 64'hFFFFF);
                check($sformatf("model_vld[%0d]", k), 64'(dut_vld[k]), 64'(m_vld[k]));
                check($sformatf("model_sat[%0d]", k), 64'(dut_sat[k]), 64'(m_satf[k]));
                check($sformatf("model_dval[%0d]", k), 64'(dut_dv[k]), 64'(m_quiet[k] >= HOLD));
            end
        end
    end

    task automatic drive(input bit v, input logic [36:0] m, input bit ps, input bit mn);
        @(negedge clk);
        dval = v; mlt = m; pair_sync = ps; mode_neg = mn;
    endtask

    task automatic idle();
        drive(1'b0, 37'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; dval = 1'b0; pair_sync = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sends A then B, then waits until the result edge has passed; checks the exact latency on u_def.
    task automatic pair_and_wait(input logic [36:0] a, input logic [36:0] b, input bit mn, input string tag);
        drive(1'b1, a, 1'b0, mn);
        drive(1'b1, b, 1'b0, mn);
        idle();
        idle();
        check({tag, "_early_vld"}, 64'(dut_vld[0]), 64'd0);
        idle();
        check({tag, "_vld"}, 64'(dut_vld[0]), 64'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [36:0] base;
        int          dprob;
        base = 37'd1 << 30;

        do_reset();
        check("rst_out", 64'(dut_out[0]), 64'd0);
        check("rst_dval", 64'(dut_dv[0]), 64'd1);

        pair_and_wait(37'd100, 37'd350, 1'b0, "pos");
        check("pos_out", 64'(dut_out[0]), 64'h008EA);
        check("pos_sat", 64'(dut_sat[0]), 64'd0);

        pair_and_wait(37'd100, 37'd350, 1'b1, "neg");
        check("neg_out", 64'(dut_out[0]), 64'h006F6);

        pair_and_wait(37'd0, 37'd1 << 20, 1'b0, "big");
        check("big_sat_out", 64'(dut_out[0]), 64'h7FFFF);
        check("big_sat_flag", 64'(dut_sat[0]), 64'd1);
        check("big_wrap_out", 64'(dut_out[1]), 64'h007F0);
        check("big_wrap_flag", 64'(dut_sat[1]), 64'd0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 37'(1000 * (i + 1)), 1'b0, 1'b0);
            check("avg_no_early_vld", 64'(dut_vld[2]), 64'd0);
            drive(1'b1, 37'(1000 * (i + 1) + 100 + 2 * i), 1'b0, 1'b0);
            check("avg_no_early_vld", 64'(dut_vld[2]), 64'd0);
        end
        idle();
        idle();
        check("avg_vld_before", 64'(dut_vld[2]), 64'd0);
        idle();
        check("avg_vld", 64'(dut_vld[2]), 64'd1);
        check("avg_out", 64'(dut_out[2]), 64'h00857);

        do_reset();
        drive(1'b1, 37'd10, 1'b0, 1'b0);
        drive(1'b1, 37'd50, 1'b1, 1'b0);
        drive(1'b1, 37'd80, 1'b0, 1'b0);
        idle();
        idle();
        idle();
        check("sync_vld", 64'(dut_vld[0]), 64'd1);
        check("sync_out", 64'(dut_out[0]), 64'h0080E);
        drive(1'b1, 37'd500, 1'b0, 1'b0);
        do_reset();
        check("midrst_out", 64'(dut_out[0]), 64'd0);
        check("midrst_sat", 64'(dut_sat[0]), 64'd0);
        check("midrst_dval", 64'(dut_dv[0]), 64'd1);
        drive(1'b1, 37'd900, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("midrst_no_vld", 64'(dut_vld[0]), 64'd0);
        end

        do_reset();
        pair_and_wait(37'd100, 37'd350, 1'b0, "hold1");
        check("hold1_dval_low", 64'(dut_dv[0]), 64'd0);
        repeat (6) idle();
        drive(1'b1, 37'd100, 1'b0, 1'b0);
        drive(1'b1, 37'd400, 1'b0, 1'b0);
        idle();
        idle();
        check("hold2_dval_low", 64'(dut_dv[0]), 64'd0);
        idle();
        check("hold2_vld", 64'(dut_vld[0]), 64'd1);
        repeat (15) idle();
        check("hold2_dval_15", 64'(dut_dv[0]), 64'd0);
        idle();
        check("hold2_dval_16", 64'(dut_dv[0]), 64'd1);

        dprob = 60;
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) dprob = (dprob == 60) ? 4 : 60;
            @(negedge clk);
            rst       = ($urandom_range(0, 299) == 0);
            dval      = ($urandom_range(0, 99) < dprob);
            pair_sync = ($urandom_range(0, 99) < 15);
            mode_neg  = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       mlt = 37'({$urandom, $urandom});
                3:       mlt = base + 37'($urandom_range(0, 1 << 21));
                default: mlt = base + 37'($urandom_range(0, 3000));
            endcase
        end
        @(negedge clk);
        rst = 1'b0; dval = 1'b0;
        repeat (5) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
